// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : MIPS program-counter sequencer. Owns the PC, feeds it to an
//               external Incrementer32 and takes the +4 result back as the
//               sequential next PC. Chooses among sequential, branch and jump
//               next-PC sources and offers the PC to fetch with a valid/ready
//               handshake. A misaligned redirect halts the sequencer, or the
//               target is force-aligned, depending on ALIGN_CHECK.
// Ports       : Clk, Reset            - clock, synchronous active-high reset
//               IncDataIn/IncDataOut  - loop through the external +4 adder
//               Stall                 - blocks sequential advance only
//               BranchTaken/Target    - absolute branch redirect
//               Jump/JumpIndex        - J-type redirect (instr_index)
//               FetchReady            - fetch accepts PcOut this cycle
//               PcOut/PcValid         - fetch request
//               Flush                 - one-cycle pulse after any redirect
//               AddrErr               - sticky misaligned-redirect flag
//               FetchCount            - count of accepted fetches (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter bit          ALIGN_CHECK  = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [31:0] IncDataIn,
    input  logic [31:0] IncDataOut,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [25:0] JumpIndex,
    input  logic        FetchReady,
    output logic [31:0] PcOut,
    output logic        PcValid,
    output logic        Flush,
    output logic        AddrErr,
    output logic [31:0] FetchCount
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_flush;
    logic        r_err;
    logic [31:0] r_cnt;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic        w_flush_nxt;
    logic        w_err_nxt;
    logic [31:0] w_cnt_nxt;

    logic [31:0] w_jump_tgt;
    logic [31:0] w_redir_tgt;
    logic        w_redirect;
    logic        w_misaligned;

    // Jump region comes from PC+4, so the incrementer output supplies the top nibble.
    assign w_jump_tgt   = {IncDataOut[31:28], JumpIndex, 2'b00};
    // Jump outranks branch; a simultaneous branch is simply dropped.
    assign w_redirect   = Jump | BranchTaken;
    assign w_redir_tgt  = Jump ? w_jump_tgt : BranchTarget;
    assign w_misaligned = ALIGN_CHECK && (w_redir_tgt[1:0] != 2'b00);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_flush_nxt = 1'b0;
        w_err_nxt   = r_err;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // An accepted fetch counts even when the PC is redirected on the same edge.
                if (FetchReady) begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
                if (w_redirect) begin
                    w_flush_nxt = 1'b1;
                    if (w_misaligned) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_HALT;
                    end else begin
                        w_pc_nxt = w_redir_tgt & ~32'h3;
                    end
                end else if (FetchReady && !Stall) begin
                    // 0xFFFF_FFFC + 4 wraps to zero naturally in the adder.
                    w_pc_nxt = IncDataOut;
                end
            end
            ST_HALT: begin
                w_err_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_VECTOR;
            r_flush <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_flush <= w_flush_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign IncDataIn  = r_pc;
    assign PcOut      = r_pc;
    assign PcValid    = (r_state == ST_RUN);
    assign Flush      = r_flush;
    assign AddrErr    = r_err;
    assign FetchCount = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer. A directed vector table
//               walks the reset, stall, jump/branch priority, misaligned halt
//               and address-wrap scenarios; a random phase then drives two
//               instances (align-check on / off with a non-zero reset vector)
//               against a behavioural model of the sequencing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam logic [31:0] C_RV1 = 32'h0000_1000;

    logic        Clk = 1'b0;
    logic        Reset, Stall, BranchTaken, Jump, FetchReady;
    logic [31:0] BranchTarget;
    logic [25:0] JumpIndex;

    logic [31:0] w_inc_in0, w_inc_out0, w_pc0, w_cnt0;
    logic        w_valid0, w_flush0, w_err0;
    logic [31:0] w_inc_in1, w_inc_out1, w_pc1, w_cnt1;
    logic        w_valid1, w_flush1, w_err1;

    // Behavioural stand-ins for the external Incrementer32.
    assign w_inc_out0 = w_inc_in0 + 32'd4;
    assign w_inc_out1 = w_inc_in1 + 32'd4;

    always #5 Clk = ~Clk;

    pc_sequencer #(.RESET_VECTOR(32'h0000_0000), .ALIGN_CHECK(1'b1)) u_dut0 (
        .Clk(Clk), .Reset(Reset), .IncDataIn(w_inc_in0), .IncDataOut(w_inc_out0),
        .Stall(Stall), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .Jump(Jump), .JumpIndex(JumpIndex), .FetchReady(FetchReady),
        .PcOut(w_pc0), .PcValid(w_valid0), .Flush(w_flush0), .AddrErr(w_err0),
        .FetchCount(w_cnt0)
    );

    pc_sequencer #(.RESET_VECTOR(C_RV1), .ALIGN_CHECK(1'b0)) u_dut1 (
        .Clk(Clk), .Reset(Reset), .IncDataIn(w_inc_in1), .IncDataOut(w_inc_out1),
        .Stall(Stall), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .Jump(Jump), .JumpIndex(JumpIndex), .FetchReady(FetchReady),
        .PcOut(w_pc1), .PcValid(w_valid1), .Flush(w_flush1), .AddrErr(w_err1),
        .FetchCount(w_cnt1)
    );

    typedef struct {
        logic        rst, stall, br, jmp, fr;
        logic [31:0] btgt;
        logic [25:0] jidx;
        logic [31:0] pc;
        logic        valid, flush, err;
        logic [31:0] cnt;
    } vec_t;

    // Model state: mode 0 = waiting one cycle after reset, 1 = running, 2 = halted.
    typedef struct {
        int          mode;
        logic [31:0] pc;
        logic [31:0] cnt;
        logic        flush;
        logic        err;
    } mdl_t;

    int   n_cmp  = 0;
    int   n_fail = 0;
    mdl_t m0, m1;

    function automatic mdl_t model_step(mdl_t m, bit align, logic [31:0] rv,
                                        logic rst, logic stall, logic br, logic jmp,
                                        logic fr, logic [31:0] btgt, logic [25:0] jidx);
        mdl_t        n;
        logic [31:0] seq;
        logic [31:0] tgt;
        n       = m;
        n.flush = 1'b0;
        seq     = m.pc + 32'd4;
        if (rst) begin
            n.mode = 0; n.pc = rv; n.cnt = 0; n.err = 1'b0;
            return n;
        end
        if (m.mode == 0) begin
            n.mode = 1;
        end else if (m.mode == 1) begin
            if (fr) n.cnt = m.cnt + 1;
            if (jmp || br) begin
                tgt     = jmp ? ((seq & 32'hF000_0000) | (32'(jidx) * 4)) : btgt;
                n.flush = 1'b1;
                if (align && (tgt % 4 != 0)) begin
                    n.err  = 1'b1;
                    n.mode = 2;
                end else begin
                    n.pc = tgt - (tgt % 4);
                end
            end else if (fr && !stall) begin
                n.pc = seq;
            end
        end
        return n;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %h, required %h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model,
    // then sample just after the rising edge.
    task automatic apply(input logic rst, input logic stall, input logic br,
                         input logic jmp, input logic fr, input logic [31:0] btgt,
                         input logic [25:0] jidx);
        @(negedge Clk);
        Reset = rst; Stall = stall; BranchTaken = br; Jump = jmp; FetchReady = fr;
        BranchTarget = btgt; JumpIndex = jidx;
        m0 = model_step(m0, 1'b1, 32'h0, rst, stall, br, jmp, fr, btgt, jidx);
        m1 = model_step(m1, 1'b0, C_RV1, rst, stall, br, jmp, fr, btgt, jidx);
        @(posedge Clk);
        #1;
    endtask

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic stall, logic br, logic jmp, logic fr,
                                logic [31:0] btgt, logic [25:0] jidx, logic [31:0] pc,
                                logic valid, logic flush, logic err, logic [31:0] cnt);
        vec_t v;
        v.rst = rst; v.stall = stall; v.br = br; v.jmp = jmp; v.fr = fr;
        v.btgt = btgt; v.jidx = jidx; v.pc = pc; v.valid = valid; v.flush = flush;
        v.err = err; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        Reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; Jump = 1'b0; FetchReady = 1'b0;
        BranchTarget = 32'h0; JumpIndex = 26'h0;
        m0 = '{mode: 0, pc: 32'h0, cnt: 32'h0, flush: 1'b0, err: 1'b0};
        m1 = '{mode: 0, pc: C_RV1, cnt: 32'h0, flush: 1'b0, err: 1'b0};

        //               rst st br jm fr btgt          jidx       pc            v  f  e  cnt
        vecs.push_back(mk(1, 0, 0, 0, 1, 32'h0,        26'h0,     32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 32'h0,        26'h0,     32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 32'h0,        26'h0,     32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0,        26'h0,     32'h0,        1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0,        26'h0,     32'h4,        1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0,        26'h0,     32'h8,        1, 0, 0, 2));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'h0,        26'h0,     32'h8,        1, 0, 0, 3));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'h0,        26'h0,     32'h8,        1, 0, 0, 4));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'h0,        26'h0,     32'h8,        1, 0, 0, 5));
        vecs.push_back(mk(0, 1, 0, 0, 1, 32'h0,        26'h0,     32'h8,        1, 0, 0, 6));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0,        26'h0,     32'hC,        1, 0, 0, 7));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0,        26'h0,     32'h10,       1, 0, 0, 8));
        vecs.push_back(mk(0, 0, 1, 1, 1, 32'h200,      26'h40,    32'h100,      1, 1, 0, 9));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0,        26'h0,     32'h104,      1, 0, 0, 10));
        vecs.push_back(mk(0, 0, 1, 0, 1, 32'h202,      26'h0,     32'h104,      0, 1, 1, 11));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0,        26'h0,     32'h104,      0, 0, 1, 11));
        vecs.push_back(mk(0, 0, 1, 0, 1, 32'h0,        26'h0,     32'h104,      0, 0, 1, 11));
        vecs.push_back(mk(1, 0, 0, 0, 1, 32'h0,        26'h0,     32'h0,        0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h0,        26'h5,     32'h0,        1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 32'hFFFF_FFF8,26'h0,     32'hFFFF_FFF8,1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0,        26'h0,     32'hFFFF_FFFC,1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0,        26'h0,     32'h0,        1, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,        26'h0,     32'h0,        1, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0,        26'h0,     32'h4,        1, 0, 0, 3));
        vecs.push_back(mk(1, 0, 0, 1, 1, 32'h0,        26'h40,    32'h0,        0, 0, 0, 0));

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].jmp, vecs[i].fr,
                  vecs[i].btgt, vecs[i].jidx);
            check("dir_pc",      i, w_pc0,              vecs[i].pc);
            check("dir_valid",   i, 32'(w_valid0),      32'(vecs[i].valid));
            check("dir_flush",   i, 32'(w_flush0),      32'(vecs[i].flush));
            check("dir_addrerr", i, 32'(w_err0),        32'(vecs[i].err));
            check("dir_count",   i, w_cnt0,             vecs[i].cnt);
            check("dir_incin",   i, w_inc_in0,          vecs[i].pc);
        end

        // Force-align instance after reset sits at its own reset vector.
        apply(1, 0, 0, 0, 0, 32'h0, 26'h0);
        check("rv1_pc", 0, w_pc1, C_RV1);
        apply(0, 0, 0, 0, 0, 32'h0, 26'h0);
        apply(0, 0, 1, 0, 1, 32'h0000_0347, 26'h0);
        check("align0_pc",  0, w_pc1, 32'h0000_0344);
        check("align0_err", 0, 32'(w_err1), 32'h0);

        // Randomised phase against the model for both instances.
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] bt;
            bt = $urandom;
            if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
            apply($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 9) < 7, bt, 26'($urandom));
            check("rnd0_pc",    c, w_pc0,           m0.pc);
            check("rnd0_valid", c, 32'(w_valid0),   32'(m0.mode == 1));
            check("rnd0_flush", c, 32'(w_flush0),   32'(m0.flush));
            check("rnd0_err",   c, 32'(w_err0),     32'(m0.err));
            check("rnd0_cnt",   c, w_cnt0,          m0.cnt);
            check("rnd0_incin", c, w_inc_in0,       m0.pc);
            check("rnd1_pc",    c, w_pc1,           m1.pc);
            check("rnd1_valid", c, 32'(w_valid1),   32'(m1.mode == 1));
            check("rnd1_flush", c, 32'(w_flush1),   32'(m1.flush));
            check("rnd1_err",   c, 32'(w_err1),     32'(m1.err));
            check("rnd1_cnt",   c, w_cnt1,          m1.cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
